dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MemW, default 33; data bus width, with bit MemW-1 as the capability tag.
REQ-002 SHALL have parameter AddrBase, default 32'h0000_0000; byte base address of the window.
REQ-003 SHALL have parameter AddrSize, default 32'h0001_0000; window size in bytes, a power of 2.
REQ-004 SHALL have parameter RspLat, default 0, range 0..3; extra response delay in cycles.
REQ-005 SHALL have parameter MaxOut, default 2, range 1..4; maximum outstanding requests.
REQ-006 SHALL have ports clk_i in 1 (clock) and rst_ni in 1 (asynchronous active-low reset); one clock only.
REQ-007 SHALL have LSU-facing ports:
- data_req_i in 1, data_gnt_o out 1
- data_we_i in 1, data_be_i in 4
- data_addr_i in 32, data_wdata_i in MemW
- data_rvalid_o out 1, data_rdata_o out MemW, data_err_o out 1
REQ-008 SHALL have gnt_stall_i in 1; forces data_gnt_o low for wait-for-grant testing.
REQ-009 SHALL have RAM-facing ports:
- ram_req_o out 1, ram_we_o out 1, ram_addr_o out 30 (word index), ram_be_o out 4
- ram_wdata_o out MemW
- ram_rdata_i in MemW; valid the cycle after a read ram_req_o.

Function
REQ-010 SHALL assert data_gnt_o = data_req_i & ~gnt_stall_i & (outstanding < MaxOut), combinationally; acceptance is the req&gnt cycle.
REQ-011 SHALL keep a 3-bit outstanding counter: +1 on acceptance, -1 on data_rvalid_o, unchanged when both occur in the same cycle.
REQ-012 SHALL, for an accepted in-range request, drive ram_req_o in the same cycle:
- ram_addr_o = (data_addr_i - AddrBase) >> 2
- ram_we_o, ram_be_o and ram_wdata_o passed through from the request
- data_addr_i[1:0] ignored
REQ-013 SHALL treat data_addr_i outside [AddrBase, AddrBase+AddrSize) as an error:
- no RAM access
- response carries data_err_o=1 and data_rdata_o=0
REQ-014 SHALL keep ram_req_o low whenever no request is accepted.
REQ-015 SHALL return the response for a request accepted in cycle T with data_rvalid_o high for exactly one cycle at T+1+RspLat.
REQ-016 SHALL return read data from ram_rdata_i sampled at T+1; when RspLat>0 that data is held in the delay line.
REQ-017 SHALL drive data_rdata_o=0 for write responses and data_err_o=0 for in-range responses.
REQ-018 SHALL return responses strictly in acceptance order; back-to-back acceptances yield back-to-back rvalids.
REQ-019 SHALL drive data_rdata_o=0 and data_err_o=0 whenever data_rvalid_o is low.
REQ-020 SHALL accept no rvalid backpressure: a response is never delayed beyond T+1+RspLat.

Reset
REQ-021 SHALL, while rst_ni=0, asynchronously clear the outstanding counter and every delay-line stage.
REQ-022 SHALL drive data_rvalid_o=0, data_err_o=0, data_rdata_o=0 and ram_req_o=0 in reset.
REQ-023 SHALL discard any in-flight responses when reset asserts mid-operation; none appear after deassertion.
REQ-024 SHALL allow a grant in the first cycle after deassertion.

Configuration
REQ-025 SHALL honour macro DMEM_RESPONDER_TAG_EN.
- Defined: a write with data_be_i != 4'hf drives ram_wdata_o[MemW-1]=0; a full-word write passes the tag through; reads return the stored tag.
- Undefined: ram_wdata_o[MemW-1] and data_rdata_o[MemW-1] are always 0.

Structure
REQ-026 SHALL define typedef dmem_rsp_t {valid, err, rdata[MemW-1:0]} and constant NULL_DMEM_RSP in the shared super package.
REQ-027 SHALL implement the delay line (RspLat+1 stages of dmem_rsp_t) as sub-module dmem_rsp_pipe.

Verification
REQ-028 SHALL test a single read: write 0x1234_5678 to word 0x10, then read with RspLat=0 -> gnt same cycle, rvalid at T+1, rdata[31:0]=0x1234_5678, err=0.
REQ-029 SHALL test address range: read 0x0001_0000 with AddrBase=0 -> ram_req_o stays 0, rvalid at T+1, err=1, rdata=0.
REQ-030 SHALL test MaxOut=2 with RspLat=3 and 3 back-to-back requests -> first two granted, third gnt low until the first rvalid cycle, rvalids in order.
REQ-031 SHALL test stall: gnt_stall_i=1 for 4 cycles with req held -> gnt=0 for 4 cycles, then granted; outstanding returns to 0 after the response.
REQ-032 SHALL test the tag with TAG_EN: full write tag=1 then read -> rdata[MemW-1]=1; then byte write be=4'h1 and read -> tag=0.
REQ-033 SHALL test reset mid-flight: rst_ni low 1 cycle while 2 responses are pending -> no rvalid afterwards, outstanding=0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
// Shared types for the data-memory responder.
//   DMEM_MEM_W    : data bus width, including the capability tag in the MSB
//   dmem_rsp_t    : one response slot {valid, err, rdata}
//   NULL_DMEM_RSP : empty slot, used for reset and idle cycles
//   dmem_in_window: true when a byte address lies in [base, base+size)
package dmem_responder_pkg;

    localparam int unsigned DMEM_MEM_W = 33;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DMEM_MEM_W-1:0] rdata;
    } dmem_rsp_t;

    localparam dmem_rsp_t NULL_DMEM_RSP = '{valid: 1'b0, err: 1'b0, rdata: '0};

    // Offset compare rather than base+size so a window ending at 2^32 works.
    function automatic logic dmem_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] size);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && (off < size);
    endfunction

endpackage

// File: rtl/dmem_responder_rsp_pipe.sv
// dmem_rsp_pipe
// Response delay line of Stages slots. Slot 0 is loaded in the acceptance
// cycle; RAM read data only exists one cycle later, so it is merged into
// slot 0 on its way out rather than being stored there.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears every slot)
//   i_push        : slot entering the line (rdata always zero)
//   i_push_rd     : the pushed slot is an in-range read and takes RAM data
//   i_ram_rdata   : RAM read data, valid the cycle after the read request
//   o_rsp         : response leaving the line
module dmem_rsp_pipe
    import dmem_responder_pkg::*;
#(
    parameter int unsigned Stages = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  dmem_rsp_t             i_push,
    input  logic                  i_push_rd,
    input  logic [DMEM_MEM_W-1:0] i_ram_rdata,
    output dmem_rsp_t             o_rsp
);

    dmem_rsp_t r_stage [Stages];
    logic      r_rd0;
    dmem_rsp_t w_eff   [Stages];

    always_comb begin
        for (int i = 0; i < int'(Stages); i++) begin
            w_eff[i] = r_stage[i];
        end
        if (r_rd0) begin
            w_eff[0].rdata = i_ram_rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Stages); i++) begin
                r_stage[i] <= NULL_DMEM_RSP;
            end
            r_rd0 <= 1'b0;
        end else begin
            r_stage[0] <= i_push;
            r_rd0      <= i_push_rd;
            for (int i = 1; i < int'(Stages); i++) begin
                r_stage[i] <= w_eff[i-1];
            end
        end
    end

    assign o_rsp = w_eff[Stages-1];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Single-window data-memory responder between an LSU-style request port and
// a word-addressed RAM. Requests are granted while fewer than MaxOut are in
// flight; every accepted request is answered exactly 1+RspLat cycles later,
// in order, with no backpressure. Out-of-window requests never reach the RAM
// and are answered with err=1.
// Optional feature macro: DMEM_RESPONDER_TAG_EN
//   defined   : capability tag (bit MemW-1) stored on full-word writes,
//               cleared on partial writes, returned on reads
//   undefined : tag is forced to zero towards the RAM and the LSU
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   data_req_i / data_gnt_o  : request handshake (gnt is combinational)
//   data_we_i, data_be_i     : write enable, byte enables
//   data_addr_i, data_wdata_i: byte address, write data
//   data_rvalid_o            : one-cycle response strobe
//   data_rdata_o, data_err_o : response data / error, zero when not valid
//   gnt_stall_i              : forces the grant low
//   ram_*                    : single-cycle RAM port, read data next cycle
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned MemW     = 33,
    parameter logic [31:0] AddrBase = 32'h0000_0000,
    parameter logic [31:0] AddrSize = 32'h0001_0000,
    parameter int unsigned RspLat   = 0,
    parameter int unsigned MaxOut   = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            data_req_i,
    output logic            data_gnt_o,
    input  logic            data_we_i,
    input  logic [3:0]      data_be_i,
    input  logic [31:0]     data_addr_i,
    input  logic [MemW-1:0] data_wdata_i,
    output logic            data_rvalid_o,
    output logic [MemW-1:0] data_rdata_o,
    output logic            data_err_o,
    input  logic            gnt_stall_i,
    output logic            ram_req_o,
    output logic            ram_we_o,
    output logic [29:0]     ram_addr_o,
    output logic [3:0]      ram_be_o,
    output logic [MemW-1:0] ram_wdata_o,
    input  logic [MemW-1:0] ram_rdata_i
);

    if (MemW != DMEM_MEM_W) begin : g_bad_memw
        $error("dmem_responder: MemW must equal DMEM_MEM_W");
    end
    if (RspLat > 3) begin : g_bad_lat
        $error("dmem_responder: RspLat out of range 0..3");
    end
    if (MaxOut < 1 || MaxOut > 4) begin : g_bad_maxout
        $error("dmem_responder: MaxOut out of range 1..4");
    end

    logic [2:0]      r_outstanding;
    logic            w_in_range;
    logic            w_gnt;
    logic            w_accept;
    logic            w_wtag;
    logic            w_rtag;
    logic [MemW-1:0] w_ram_rdata;
    dmem_rsp_t       w_push;
    dmem_rsp_t       w_rsp;

`ifdef DMEM_RESPONDER_TAG_EN
    // A partial write cannot vouch for the whole word, so it drops the tag.
    assign w_wtag = (data_be_i == 4'hf) ? data_wdata_i[MemW-1] : 1'b0;
    assign w_rtag = ram_rdata_i[MemW-1];
`else
    logic w_unused_tag;
    assign w_unused_tag = data_wdata_i[MemW-1] ^ ram_rdata_i[MemW-1];
    assign w_wtag       = 1'b0;
    assign w_rtag       = 1'b0;
`endif

    assign w_in_range = dmem_in_window(data_addr_i, AddrBase, AddrSize);

    // rst_ni in the grant keeps the RAM port quiet while reset is held.
    assign w_gnt    = rst_ni & data_req_i & ~gnt_stall_i
                      & (r_outstanding < 3'(MaxOut));
    assign w_accept = data_req_i & w_gnt;

    assign data_gnt_o  = w_gnt;
    assign ram_req_o   = w_accept & w_in_range;
    assign ram_we_o    = data_we_i;
    assign ram_be_o    = data_be_i;
    assign ram_addr_o  = data_addr_i[31:2] - AddrBase[31:2];
    assign ram_wdata_o = {w_wtag, data_wdata_i[MemW-2:0]};
    assign w_ram_rdata = {w_rtag, ram_rdata_i[MemW-2:0]};

    always_comb begin
        w_push       = NULL_DMEM_RSP;
        w_push.valid = w_accept;
        w_push.err   = w_accept & ~w_in_range;
    end

    dmem_rsp_pipe #(
        .Stages (RspLat + 1)
    ) u_rsp_pipe (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_push      (w_push),
        .i_push_rd   (w_accept & w_in_range & ~data_we_i),
        .i_ram_rdata (w_ram_rdata),
        .o_rsp       (w_rsp)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= 3'd0;
        end else if (w_accept && !w_rsp.valid) begin
            r_outstanding <= r_outstanding + 3'd1;
        end else if (!w_accept && w_rsp.valid) begin
            r_outstanding <= r_outstanding - 3'd1;
        end
    end

    assign data_rvalid_o = w_rsp.valid;
    assign data_err_o    = w_rsp.valid & w_rsp.err;
    assign data_rdata_o  = w_rsp.valid ? w_rsp.rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_TAG_EN
    localparam bit TagEn = 1'b1;
`else
    localparam bit TagEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic        req   [2];
    logic        we    [2];
    logic        stall [2];
    logic [3:0]  be    [2];
    logic [31:0] addr  [2];
    logic [32:0] wdata [2];

    logic        gnt       [2];
    logic        rvalid    [2];
    logic        err       [2];
    logic [32:0] rdata     [2];
    logic        ram_req   [2];
    logic        ram_we    [2];
    logic [29:0] ram_addr  [2];
    logic [3:0]  ram_be    [2];
    logic [32:0] ram_wdata [2];

    typedef struct {
        int          due;
        logic        err;
        logic [32:0] rdata;
    } exp_t;

    function automatic logic [31:0] base_of(int d);
        return (d == 0) ? 32'h0000_0000 : 32'h2000_0000;
    endfunction

    function automatic logic [31:0] size_of(int d);
        return (d == 0) ? 32'h0001_0000 : 32'h0000_1000;
    endfunction

    // dut0: RspLat=0, dut1: RspLat=3 with a non-zero base; both MaxOut=2
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT  = (g == 0) ? 0 : 3;
        localparam logic [31:0] BASE = (g == 0) ? 32'h0000_0000 : 32'h2000_0000;
        localparam logic [31:0] SIZE = (g == 0) ? 32'h0001_0000 : 32'h0000_1000;

        logic [32:0] ram_rdata;
        logic [32:0] ram_mem [int];
        logic [32:0] gold    [int];
        logic [32:0] ram_word;
        logic [32:0] gold_word;
        exp_t        q [$];
        exp_t        m_e;
        logic        exp_gnt;
        logic        inr;
        logic [32:0] exp_wd;
        int          gidx;

        dmem_responder #(
            .MemW     (33),
            .AddrBase (BASE),
            .AddrSize (SIZE),
            .RspLat   (LAT),
            .MaxOut   (2)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .data_req_i    (req[g]),
            .data_gnt_o    (gnt[g]),
            .data_we_i     (we[g]),
            .data_be_i     (be[g]),
            .data_addr_i   (addr[g]),
            .data_wdata_i  (wdata[g]),
            .data_rvalid_o (rvalid[g]),
            .data_rdata_o  (rdata[g]),
            .data_err_o    (err[g]),
            .gnt_stall_i   (stall[g]),
            .ram_req_o     (ram_req[g]),
            .ram_we_o      (ram_we[g]),
            .ram_addr_o    (ram_addr[g]),
            .ram_be_o      (ram_be[g]),
            .ram_wdata_o   (ram_wdata[g]),
            .ram_rdata_i   (ram_rdata)
        );

        // Behavioural RAM; read data is garbage except the cycle after a read.
        always @(posedge clk) begin
            if (ram_req[g] === 1'b1 && ram_we[g] === 1'b1) begin
                ram_word = ram_mem.exists(int'(ram_addr[g])) ? ram_mem[int'(ram_addr[g])] : 33'h0;
                for (int b = 0; b < 4; b++)
                    if (ram_be[g][b]) ram_word[8*b +: 8] = ram_wdata[g][8*b +: 8];
                ram_word[32] = ram_wdata[g][32];
                ram_mem[int'(ram_addr[g])] = ram_word;
                ram_rdata <= {1'($urandom_range(0, 1)), $urandom};
            end else if (ram_req[g] === 1'b1) begin
                ram_rdata <= ram_mem.exists(int'(ram_addr[g])) ? ram_mem[int'(ram_addr[g])] : 33'h0;
            end else begin
                ram_rdata <= {1'($urandom_range(0, 1)), $urandom};
            end
        end

        // Reference: queue of expected responses with due cycles, golden memory.
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                n_checks++;
                if (rvalid[g] !== 1'b0 || err[g] !== 1'b0 || rdata[g] !== 33'h0 || ram_req[g] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_outputs dut%0d: rvalid=%b err=%b rdata=%h ram_req=%b, required all 0",
                             g, rvalid[g], err[g], rdata[g], ram_req[g]);
                end
            end else begin
                exp_gnt = req[g] && !stall[g] && (q.size() < 2);
                inr     = (addr[g] >= BASE) && ((addr[g] - BASE) < SIZE);
                n_checks++;
                if (gnt[g] !== exp_gnt) begin
                    n_fail++;
                    $display("FAIL grant dut%0d cyc %0d: gnt=%b required %b", g, cyc, gnt[g], exp_gnt);
                end
                n_checks++;
                if (ram_req[g] !== (exp_gnt && inr)) begin
                    n_fail++;
                    $display("FAIL ram_req dut%0d cyc %0d: ram_req=%b required %b", g, cyc, ram_req[g], exp_gnt && inr);
                end
                if (exp_gnt && inr) begin
                    exp_wd = {(TagEn && be[g] == 4'hf) ? wdata[g][32] : 1'b0, wdata[g][31:0]};
                    n_checks++;
                    if (ram_addr[g] !== 30'((addr[g] - BASE) >> 2) || ram_we[g] !== we[g] || ram_be[g] !== be[g]
                        || (we[g] && ram_wdata[g] !== exp_wd)) begin
                        n_fail++;
                        $display("FAIL ram_port dut%0d cyc %0d: addr=%h we=%b be=%h wdata=%h required addr=%h we=%b be=%h wdata=%h",
                                 g, cyc, ram_addr[g], ram_we[g], ram_be[g], ram_wdata[g],
                                 30'((addr[g] - BASE) >> 2), we[g], be[g], exp_wd);
                    end
                end
                if (rvalid[g] === 1'b1) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_rvalid dut%0d cyc %0d: rvalid=1 required 0", g, cyc);
                    end else begin
                        m_e = q.pop_front();
                        if (m_e.due != cyc || err[g] !== m_e.err || rdata[g] !== m_e.rdata) begin
                            n_fail++;
                            $display("FAIL response dut%0d cyc %0d: err=%b rdata=%h required cyc %0d err=%b rdata=%h",
                                     g, cyc, err[g], rdata[g], m_e.due, m_e.err, m_e.rdata);
                        end
                    end
                end else begin
                    n_checks++;
                    if (err[g] !== 1'b0 || rdata[g] !== 33'h0) begin
                        n_fail++;
                        $display("FAIL idle_outputs dut%0d cyc %0d: err=%b rdata=%h required 0", g, cyc, err[g], rdata[g]);
                    end
                    if (q.size() > 0 && q[0].due <= cyc) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL missing_rvalid dut%0d cyc %0d: rvalid=0 required 1", g, cyc);
                        void'(q.pop_front());
                    end
                end
                if (req[g] === 1'b1 && gnt[g] === 1'b1) begin
                    m_e.due   = cyc + 1 + int'(LAT);
                    m_e.err   = !inr;
                    m_e.rdata = 33'h0;
                    if (inr) begin
                        gidx = int'((addr[g] - BASE) >> 2);
                        gold_word = gold.exists(gidx) ? gold[gidx] : 33'h0;
                        if (we[g]) begin
                            for (int b = 0; b < 4; b++)
                                if (be[g][b]) gold_word[8*b +: 8] = wdata[g][8*b +: 8];
                            gold_word[32] = TagEn && (be[g] == 4'hf) && wdata[g][32];
                            gold[gidx] = gold_word;
                        end else begin
                            m_e.rdata = gold_word;
                        end
                    end
                    q.push_back(m_e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int d, logic r, logic w, logic [3:0] b, logic [31:0] a, logic [32:0] wd);
        req[d] = r; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    endtask

    task automatic idle(int d);
        set_req(d, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0);
    endtask

    // Holds a request until granted; returns just after the accepting edge.
    task automatic issue(int d, logic w, logic [3:0] b, logic [31:0] a, logic [32:0] wd);
        int waited = 0;
        set_req(d, 1'b1, w, b, a, wd);
        @(negedge clk);
        while (gnt[d] !== 1'b1 && waited < 20) begin
            step();
            @(negedge clk);
            waited++;
        end
        if (gnt[d] !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout dut%0d: gnt=%b after %0d cycles, required 1", d, gnt[d], waited);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            idle(d);
            stall[d] = 1'b0;
        end
        set_req(0, 1'b1, 1'b0, 4'hf, 32'h0, 33'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (rvalid[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 33'h0 || ram_req[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: rvalid=%b err=%b rdata=%h ram_req=%b, required all 0",
                         d, rvalid[d], err[d], rdata[d], ram_req[d]);
            end
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL first_cycle_grant: gnt=%b required 1", gnt[0]);
        end
        step();
        idle(0);
        repeat (2) step();
    endtask

    task automatic test_single_read();
        issue(0, 1'b1, 4'hf, 32'h0000_0040, 33'h0_1234_5678);
        set_req(0, 1'b1, 1'b0, 4'hf, 32'h0000_0040, 33'h0);
        @(negedge clk);
        n_checks++;
        if (gnt[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_read_gnt: gnt=%b required 1", gnt[0]);
        end
        step();
        idle(0);
        @(negedge clk);
        n_checks++;
        if (rvalid[0] !== 1'b1 || rdata[0][31:0] !== 32'h1234_5678 || err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_rsp: rvalid=%b rdata=%h err=%b required 1 12345678 0",
                     rvalid[0], rdata[0][31:0], err[0]);
        end
        step();
    endtask

    task automatic test_range();
        set_req(0, 1'b1, 1'b0, 4'hf, 32'h0001_0000, 33'h0);
        @(negedge clk);
        n_checks++;
        if (gnt[0] !== 1'b1 || ram_req[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL range_req: gnt=%b ram_req=%b required 1 0", gnt[0], ram_req[0]);
        end
        step();
        idle(0);
        @(negedge clk);
        n_checks++;
        if (rvalid[0] !== 1'b1 || err[0] !== 1'b1 || rdata[0] !== 33'h0) begin
            n_fail++;
            $display("FAIL range_rsp: rvalid=%b err=%b rdata=%h required 1 1 0", rvalid[0], err[0], rdata[0]);
        end
        step();
    endtask

    task automatic test_maxout();
        logic [31:0] b;
        int low, first_rv, n_rv;
        logic [32:0] last_rd;
        b = base_of(1);
        issue(1, 1'b1, 4'hf, b + 32'h0, 33'h0_AAAA_0000);
        issue(1, 1'b1, 4'hf, b + 32'h4, 33'h0_BBBB_1111);
        issue(1, 1'b1, 4'hf, b + 32'h8, 33'h0_CCCC_2222);
        idle(1);
        repeat (8) step();
        set_req(1, 1'b1, 1'b0, 4'hf, b + 32'h0, 33'h0);
        @(negedge clk);
        n_checks++;
        if (gnt[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL maxout_gnt1: gnt=%b required 1", gnt[1]);
        end
        step();
        set_req(1, 1'b1, 1'b0, 4'hf, b + 32'h4, 33'h0);
        @(negedge clk);
        n_checks++;
        if (gnt[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL maxout_gnt2: gnt=%b required 1", gnt[1]);
        end
        step();
        set_req(1, 1'b1, 1'b0, 4'hf, b + 32'h8, 33'h0);
        low = 0; first_rv = -1; n_rv = 0; last_rd = 33'h0;
        @(negedge clk);
        while (gnt[1] !== 1'b1 && low < 10) begin
            if (rvalid[1] === 1'b1) begin
                if (first_rv < 0) first_rv = low;
                n_rv++;
                last_rd = rdata[1];
            end
            low++;
            step();
            @(negedge clk);
        end
        if (rvalid[1] === 1'b1) begin n_rv++; last_rd = rdata[1]; end
        n_checks++;
        if (low != 3 || first_rv != 2) begin
            n_fail++;
            $display("FAIL maxout_third_wait: low cycles=%0d first rvalid at %0d, required 3 and 2", low, first_rv);
        end
        step();
        idle(1);
        repeat (8) begin
            @(negedge clk);
            if (rvalid[1] === 1'b1) begin n_rv++; last_rd = rdata[1]; end
            step();
        end
        n_checks++;
        if (n_rv != 3 || last_rd !== 33'h0_CCCC_2222) begin
            n_fail++;
            $display("FAIL maxout_order: %0d rvalids last rdata=%h, required 3 and 0cccc2222", n_rv, last_rd);
        end
    endtask

    task automatic test_stall();
        logic [31:0] b;
        b = base_of(1);
        stall[1] = 1'b1;
        set_req(1, 1'b1, 1'b0, 4'hf, b + 32'h4, 33'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_gnt_low cycle %0d: gnt=%b required 0", i, gnt[1]);
            end
            step();
        end
        stall[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gnt[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_gnt: gnt=%b required 1", gnt[1]);
        end
        step();
        idle(1);
        repeat (6) step();
        // With nothing in flight, MaxOut=2 back-to-back requests are granted at once.
        for (int i = 0; i < 2; i++) begin
            set_req(1, 1'b1, 1'b0, 4'hf, b + 32'(8 * i), 33'h0);
            @(negedge clk);
            n_checks++;
            if (gnt[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_drained_gnt%0d: gnt=%b required 1", i, gnt[1]);
            end
            step();
        end
        idle(1);
        repeat (6) step();
    endtask

    task automatic test_tag();
        issue(0, 1'b1, 4'hf, 32'h0000_0080, 33'h1_CAFE_F00D);
        set_req(0, 1'b1, 1'b0, 4'hf, 32'h0000_0080, 33'h0);
        @(negedge clk);
        step();
        idle(0);
        @(negedge clk);
        n_checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== {TagEn, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL tag_full_write: rvalid=%b rdata=%h required 1 %h", rvalid[0], rdata[0], {TagEn, 32'hCAFE_F00D});
        end
        step();
        issue(0, 1'b1, 4'h1, 32'h0000_0080, 33'h1_0000_0055);
        set_req(0, 1'b1, 1'b0, 4'hf, 32'h0000_0080, 33'h0);
        @(negedge clk);
        step();
        idle(0);
        @(negedge clk);
        n_checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 33'h0_CAFE_F055) begin
            n_fail++;
            $display("FAIL tag_byte_write: rvalid=%b rdata=%h required 1 0cafef055", rvalid[0], rdata[0]);
        end
        step();
    endtask

    task automatic test_random(int d);
        logic [31:0] a;
        int sel;
        for (int i = 0; i < 300; i++) begin
            step();
            stall[d] = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = base_of(d) + size_of(d) + 32'($urandom_range(0, 255));
            else if (sel == 1) a = base_of(d) - 32'd4;
            else               a = base_of(d) + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            set_req(d, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a,
                    {1'($urandom_range(0, 1)), $urandom});
        end
        step();
        idle(d);
        stall[d] = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_reset_midflight();
        logic [31:0] b;
        int n_rv;
        b = base_of(1);
        for (int i = 0; i < 2; i++) begin
            set_req(1, 1'b1, 1'b0, 4'hf, b + 32'(4 * i), 33'h0);
            @(negedge clk);
            n_checks++;
            if (gnt[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL midflight_gnt%0d: gnt=%b required 1", i, gnt[1]);
            end
            step();
        end
        idle(1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_rv = 0;
        repeat (8) begin
            @(negedge clk);
            if (rvalid[1] === 1'b1) n_rv++;
            step();
        end
        n_checks++;
        if (n_rv != 0) begin
            n_fail++;
            $display("FAIL midflight_rvalid: %0d rvalids after reset, required 0", n_rv);
        end
        for (int i = 0; i < 2; i++) begin
            set_req(1, 1'b1, 1'b0, 4'hf, b + 32'(4 * i), 33'h0);
            @(negedge clk);
            n_checks++;
            if (gnt[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL midflight_drained_gnt%0d: gnt=%b required 1", i, gnt[1]);
            end
            step();
        end
        idle(1);
        repeat (6) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_range();
        test_maxout();
        test_stall();
        test_tag();
        test_random(0);
        test_random(1);
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
